// File: rtl/dca_matrix_lsu_row_unpacker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : dca_matrix_lsu_row_unpacker                                        |
// | Brief  : Collects memory read beats into a matrix row, unpacks/extends the  |
// |          packed elements and queues finished rows in a small output FIFO.  |
// |          Optional macro DCA_ROW_UNPACKER_COL_MASK_EN adds in_col_mask.      |
// | Rev    : 1.0 - initial release                                              |
// +----------------------------------------------------------------------------+
module dca_matrix_lsu_row_unpacker #(
    parameter int MATRIX_NUM_COL = 4,
    parameter int BW_MEM_BEAT    = 32,
    parameter int BW_LSU_ELEMENT = 32,
    parameter int BW_TXN_INFO    = 8,
    parameter int OUT_DEPTH      = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [BW_MEM_BEAT-1:0]                   in_data,
    input  logic [BW_TXN_INFO-1:0]                   in_txn_info,
    input  logic [2:0]                               in_size,
    input  logic                                     in_signed,
`ifdef DCA_ROW_UNPACKER_COL_MASK_EN
    input  logic [MATRIX_NUM_COL-1:0]                in_col_mask,
`endif
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [BW_LSU_ELEMENT*MATRIX_NUM_COL-1:0] out_row,
    output logic [BW_TXN_INFO-1:0]                   out_txn_info
);

    // Worst case is 32-bit elements, which sets the assembly buffer depth.
    localparam int c_max_beats = (MATRIX_NUM_COL * 32 + BW_MEM_BEAT - 1) / BW_MEM_BEAT;
    localparam int c_cnt_w     = (c_max_beats > 1) ? $clog2(c_max_beats) : 1;
    localparam int c_buf_w     = c_max_beats * BW_MEM_BEAT;
    localparam int c_ext_w     = c_buf_w + BW_LSU_ELEMENT;
    localparam int c_row_w     = BW_LSU_ELEMENT * MATRIX_NUM_COL;
    localparam int c_ptr_w     = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int c_occ_w     = $clog2(OUT_DEPTH + 1);

    localparam logic [c_cnt_w:0]   c_nb_one    = 1;
    localparam logic [c_cnt_w-1:0] c_cnt_one   = 1;
    localparam logic [c_ptr_w-1:0] c_ptr_one   = 1;
    localparam logic [c_ptr_w-1:0] c_ptr_last  = c_ptr_w'(OUT_DEPTH - 1);
    localparam logic [c_occ_w-1:0] c_occ_one   = 1;
    localparam logic [c_occ_w-1:0] c_depth     = c_occ_w'(OUT_DEPTH);

    localparam logic [0:0] c_s_idle    = 1'b0;
    localparam logic [0:0] c_s_collect = 1'b1;

    function automatic logic [c_cnt_w:0] f_nbeats(input logic [2:0] s);
        int n;
        n = ((MATRIX_NUM_COL << s) + BW_MEM_BEAT - 1) / BW_MEM_BEAT;
        if (n < 1) n = 1;
        return n[c_cnt_w:0];
    endfunction

    logic [0:0]               r_state;
    logic [c_cnt_w-1:0]       r_cnt;
    logic [c_buf_w-1:0]       r_buf;
    logic [2:0]               r_size;
    logic                     r_signed;
    logic [BW_TXN_INFO-1:0]   r_txn;
    logic [c_row_w-1:0]       r_mem_row [OUT_DEPTH];
    logic [BW_TXN_INFO-1:0]   r_mem_txn [OUT_DEPTH];
    logic [c_ptr_w-1:0]       r_wr_ptr;
    logic [c_ptr_w-1:0]       r_rd_ptr;
    logic [c_occ_w-1:0]       r_occ;

    logic                     w_first;
    logic [2:0]               w_size;
    logic                     w_sign;
    logic [BW_TXN_INFO-1:0]   w_txn;
    logic [c_cnt_w:0]         w_nbeats;
    logic                     w_last;
    logic                     w_acc;
    logic                     w_push;
    logic                     w_pop;
    logic [c_buf_w-1:0]       w_asm;
    logic [c_ext_w-1:0]       w_sh;
    logic [BW_LSU_ELEMENT-1:0] w_el;
    logic [BW_LSU_ELEMENT-1:0] w_msk;
    logic [c_row_w-1:0]       w_row;
    logic [MATRIX_NUM_COL-1:0] w_mask;

`ifdef DCA_ROW_UNPACKER_COL_MASK_EN
    logic [MATRIX_NUM_COL-1:0] r_mask;
    assign w_mask = w_first ? in_col_mask : r_mask;
`else
    assign w_mask = '1;
`endif

    // Row sideband comes straight from the inputs on beat 0, from the latches after.
    assign w_first  = (r_state == c_s_idle);
    assign w_size   = w_first ? ((in_size > 3'd5) ? 3'd5 : in_size) : r_size;
    assign w_sign   = w_first ? in_signed : r_signed;
    assign w_txn    = w_first ? in_txn_info : r_txn;
    assign w_nbeats = f_nbeats(w_size);
    assign w_last   = ({1'b0, r_cnt} == (w_nbeats - c_nb_one));
    assign in_ready = !rst && (!w_last || (r_occ < c_depth));
    assign w_acc    = in_valid && in_ready;
    assign w_push   = w_acc && w_last;
    assign w_pop    = (r_occ != '0) && out_ready;

    always_comb begin
        w_asm = r_buf;
        w_asm[BW_MEM_BEAT * r_cnt +: BW_MEM_BEAT] = in_data;
    end

    always_comb begin
        w_row = '0;
        w_sh  = '0;
        w_el  = '0;
        w_msk = ~({BW_LSU_ELEMENT{1'b1}} << (32'd1 << w_size));
        for (int i = 0; i < MATRIX_NUM_COL; i++) begin
            w_sh = {{BW_LSU_ELEMENT{1'b0}}, w_asm} >> (i << w_size);
            w_el = w_sh[BW_LSU_ELEMENT-1:0] & w_msk;
            // Single-bit elements have no sign bit to extend.
            if (w_sign && (w_size != 3'd0) && w_el[(32'd1 << w_size) - 32'd1])
                w_el = w_el | ~w_msk;
            if (!w_mask[i])
                w_el = '0;
            w_row[i*BW_LSU_ELEMENT +: BW_LSU_ELEMENT] = w_el;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_s_idle;
            r_cnt    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_acc) begin
                r_buf[BW_MEM_BEAT * r_cnt +: BW_MEM_BEAT] <= in_data;
                if (w_first) begin
                    r_size   <= w_size;
                    r_signed <= in_signed;
                    r_txn    <= in_txn_info;
`ifdef DCA_ROW_UNPACKER_COL_MASK_EN
                    r_mask   <= in_col_mask;
`endif
                end
                if (w_last) begin
                    r_state <= c_s_idle;
                    r_cnt   <= '0;
                end else begin
                    r_state <= c_s_collect;
                    r_cnt   <= r_cnt + c_cnt_one;
                end
            end
            if (w_push) begin
                r_mem_row[r_wr_ptr] <= w_row;
                r_mem_txn[r_wr_ptr] <= w_txn;
                r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + c_ptr_one;
            end
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + c_ptr_one;
            if (w_push && !w_pop)
                r_occ <= r_occ + c_occ_one;
            else if (!w_push && w_pop)
                r_occ <= r_occ - c_occ_one;
        end
    end

    // Output is gated so an empty FIFO always presents zeros.
    assign out_valid    = (r_occ != '0);
    assign out_row      = out_valid ? r_mem_row[r_rd_ptr] : '0;
    assign out_txn_info = out_valid ? r_mem_txn[r_rd_ptr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_dca_matrix_lsu_row_unpacker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_dca_matrix_lsu_row_unpacker                                     |
// | Brief  : Directed vectors plus random rows against a row-level model.       |
// | Rev    : 1.0 - initial release                                              |
// +----------------------------------------------------------------------------+
module tb_dca_matrix_lsu_row_unpacker;

    localparam int C   = 4;
    localparam int BMB = 32;
    localparam int BLE = 32;
    localparam int TXW = 8;
    localparam int D   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [BMB-1:0]   in_data;
    logic [TXW-1:0]   in_txn_info;
    logic [2:0]       in_size;
    logic             in_signed;
    logic [C-1:0]     in_col_mask;
    logic             out_valid;
    logic             out_ready;
    logic [C*BLE-1:0] out_row;
    logic [TXW-1:0]   out_txn_info;

    int n_checks = 0;
    int n_fail   = 0;
    bit done     = 0;

    dca_matrix_lsu_row_unpacker #(
        .MATRIX_NUM_COL(C), .BW_MEM_BEAT(BMB), .BW_LSU_ELEMENT(BLE),
        .BW_TXN_INFO(TXW), .OUT_DEPTH(D)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_txn_info(in_txn_info), .in_size(in_size), .in_signed(in_signed),
`ifdef DCA_ROW_UNPACKER_COL_MASK_EN
        .in_col_mask(in_col_mask),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_txn_info(out_txn_info)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nbeats(input logic [2:0] sz);
        int e, n;
        e = (sz > 3'd5) ? 5 : int'(sz);
        n = (C * (1 << e) + BMB - 1) / BMB;
        return (n < 1) ? 1 : n;
    endfunction

    // Row value from first principles: element i is the integer held in bits
    // W*i..W*i+W-1 of the beat stream, optionally read as two's complement.
    function automatic logic [C*BLE-1:0] model_row(input logic [BMB-1:0] b0, b1, b2, b3,
                                                   input int n, input logic [2:0] sz,
                                                   input logic sg, input logic [C-1:0] mk);
        logic [127:0] stream;
        logic [BMB-1:0] bl [4];
        logic [C*BLE-1:0] row;
        longint unsigned v;
        int e, w;
        bl[0] = b0; bl[1] = b1; bl[2] = b2; bl[3] = b3;
        stream = '0;
        for (int k = 0; k < n; k++) stream = stream | (128'(bl[k]) << (32 * k));
        e = (sz > 3'd5) ? 5 : int'(sz);
        w = 1 << e;
        row = '0;
        for (int i = 0; i < C; i++) begin
            v = 64'(stream >> (w * i)) % (64'd1 << w);
            if (sg && w > 1 && v >= (64'd1 << (w - 1))) v = v + (64'd1 << 32) - (64'd1 << w);
            if (!mk[i]) v = 0;
            row[32*i +: 32] = v[31:0];
        end
        return row;
    endfunction

    // Reference model state: partial row, occupancy and expected output queue.
    int               occ = 0;
    int               m_cnt = 0;
    int               m_n = 1;
    logic [2:0]       m_size;
    logic             m_sg;
    logic [TXW-1:0]   m_txn;
    logic [C-1:0]     m_mask;
    logic [BMB-1:0]   m_beats [4];
    logic [C*BLE-1:0] exp_row [$];
    logic [TXW-1:0]   exp_txn [$];
    bit               hold_prev = 0;
    logic [C*BLE-1:0] held_row;
    logic [TXW-1:0]   held_txn;

    always @(negedge clk) begin
        int  n_cur;
        bit  pushed, popped;
        logic exp_rdy;
        pushed = 0;
        popped = 0;
        check("out_valid", out_valid, occ > 0);
        if (hold_prev && out_valid) begin
            check("hold_row", out_row, held_row);
            check("hold_txn", out_txn_info, held_txn);
        end
        if (out_valid && out_ready) begin
            if (exp_row.size() == 0) check("unexpected_pop", 1, 0);
            else begin
                check("sb_row", out_row, exp_row.pop_front());
                check("sb_txn", out_txn_info, exp_txn.pop_front());
            end
            popped = 1;
        end
        n_cur   = (m_cnt == 0) ? nbeats(in_size) : m_n;
        exp_rdy = !rst && ((m_cnt != n_cur - 1) || (occ < D));
        check("in_ready", in_ready, exp_rdy);
        if (!rst && in_valid && in_ready) begin
            if (m_cnt == 0) begin
                m_n = n_cur; m_size = in_size; m_sg = in_signed;
                m_txn = in_txn_info; m_mask = in_col_mask;
            end
            m_beats[m_cnt] = in_data;
            m_cnt++;
            if (m_cnt == m_n) begin
                exp_row.push_back(model_row(m_beats[0], m_beats[1], m_beats[2], m_beats[3],
                                            m_n, m_size, m_sg, m_mask));
                exp_txn.push_back(m_txn);
                m_cnt  = 0;
                pushed = 1;
            end
        end
        occ = occ + int'(pushed) - int'(popped);
        hold_prev = out_valid && !out_ready;
        held_row  = out_row;
        held_txn  = out_txn_info;
        if (rst) begin
            occ = 0; m_cnt = 0; hold_prev = 0;
            exp_row.delete(); exp_txn.delete();
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input logic [BMB-1:0] d, input logic [2:0] sz, input logic sg,
                             input logic [TXW-1:0] txn, input logic [C-1:0] mk);
        int t;
        in_valid = 1; in_data = d; in_size = sz; in_signed = sg;
        in_txn_info = txn; in_col_mask = mk;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin @(negedge clk); t++; end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        cyc();
        in_valid = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; in_valid = 0; in_data = '0; in_size = '0; in_signed = 0;
        in_txn_info = '0; in_col_mask = '1; out_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        cyc();

        send_beat(32'h807F01FF, 3'd3, 1'b1, 8'hA1, 4'hF);
        @(negedge clk);
        check("r029_valid", out_valid, 1);
        check("r029_row", out_row, {32'hFFFFFF80, 32'h0000007F, 32'h00000001, 32'hFFFFFFFF});
        check("r029_txn", out_txn_info, 8'hA1);
        cyc();

        send_beat(32'hFFFFA5C3, 3'd2, 1'b0, 8'h5E, 4'hF);
        @(negedge clk);
        check("r030_row", out_row, {32'hA, 32'h5, 32'hC, 32'h3});
        cyc();

        for (int k = 0; k < 4; k++) begin
            send_beat(32'h11111111 * (k + 1), (k == 0) ? 3'd5 : 3'd0, 1'b1,
                      (k == 0) ? 8'h31 : 8'hEE, 4'hF);
            @(negedge clk);
            if (k < 3) begin
                check("r031_novalid", out_valid, 0);
                cyc(); cyc();
            end
        end
        check("r031_row", out_row, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
        check("r031_txn", out_txn_info, 8'h31);
        cyc();

        out_ready = 0;
        send_beat(32'h01010101, 3'd3, 1'b0, 8'h01, 4'hF);
        send_beat(32'h02020202, 3'd3, 1'b0, 8'h02, 4'hF);
        in_valid = 1; in_data = 32'h03030303; in_txn_info = 8'h03;
        @(negedge clk);
        check("r032_stall", in_ready, 0);
        cyc();
        out_ready = 1;
        @(negedge clk);
        check("r032_still_full", in_ready, 0);
        check("r032_first", out_txn_info, 8'h01);
        cyc();
        @(negedge clk);
        check("r032_accept", in_ready, 1);
        cyc();
        in_valid = 0;
        repeat (4) cyc();

        send_beat(32'hDEAD0001, 3'd5, 1'b1, 8'hBB, 4'hF);
        send_beat(32'hDEAD0002, 3'd5, 1'b1, 8'hBB, 4'hF);
        rst = 1;
        cyc();
        rst = 0;
        send_beat(32'h04030201, 3'd3, 1'b0, 8'h77, 4'hF);
        @(negedge clk);
        check("r033_row", out_row, {32'h4, 32'h3, 32'h2, 32'h1});
        check("r033_txn", out_txn_info, 8'h77);
        cyc();

`ifdef DCA_ROW_UNPACKER_COL_MASK_EN
        send_beat(32'h04030201, 3'd3, 1'b0, 8'h34, 4'b0101);
        @(negedge clk);
        check("r034_row", out_row, {32'h0, 32'h3, 32'h0, 32'h1});
        cyc();
`endif

        fork
            begin
                for (int r = 0; r < 40; r++) begin
                    logic [2:0] sz;
                    logic [C-1:0] mk;
                    int n;
                    sz = 3'($urandom_range(0, 7));
                    n  = nbeats(sz);
`ifdef DCA_ROW_UNPACKER_COL_MASK_EN
                    mk = C'($urandom);
`else
                    mk = '1;
`endif
                    for (int k = 0; k < n; k++) begin
                        send_beat($urandom, (k == 0) ? sz : 3'($urandom), 1'($urandom),
                                  TXW'($urandom), (k == 0) ? mk : '1);
                        repeat ($urandom_range(0, 2)) cyc();
                    end
                end
                done = 1;
            end
            begin
                while (!done) begin
                    cyc();
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1;
            end
        join

        for (int t = 0; t < 200 && occ != 0; t++) cyc();
        check("drain_empty", occ == 0, 1);
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
